atc_pipe: RTL and testbench
===========================

Name: atc_pipe

Overview:
Parametrised hazard-tracking pipeline for register-address/result-type tuples (ra1, ra2, wa, res), generalising the single fixed M->W stage register to STAGES stages (default E, M, W).
- Each stage carries a valid bit and a saturating Tnew countdown.
- Stall, flush and freeze are built in.
- A combinational stall request is generated from the D-stage read addresses against all in-flight writes.
- Sits beside the datapath pipeline registers and feeds the hazard/forwarding control.

Parameters:
AW, 5, register address width
RW, 3, result-type code width
TW, 2, Tnew/Tuse width
STAGES, 3, number of tracked stages (>=2); stage 0 = E, stage STAGES-1 = W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  D-stage tuple valid
in_ra1  input  AW  D-stage read address 1
in_ra2  input  AW  D-stage read address 2
in_wa  input  AW  D-stage write address; 0 = no write
in_res  input  RW  D-stage result type
in_tnew  input  TW  cycles until result ready, measured at stage 0
in_tuse1  input  TW  cycles until ra1 operand needed, measured at D
in_tuse2  input  TW  cycles until ra2 operand needed, measured at D
ext_stall  input  1  external stall (e.g. multiplier busy)
freeze  input  1  hold every stage unchanged
flush  input  STAGES  per-stage kill vector; bit i bubbles stage i's next value
stall_req  output  1  combinational data-hazard stall request
ra1_o  output  STAGES*AW  per-stage ra1, stage i at [i*AW +: AW]
ra2_o  output  STAGES*AW  per-stage ra2
wa_o  output  STAGES*AW  per-stage wa
res_o  output  STAGES*RW  per-stage result type
tnew_o  output  STAGES*TW  per-stage remaining Tnew
valid_o  output  STAGES  per-stage valid

Behaviour:
- Reset: rst low asynchronously clears every stage to bubble (all fields 0, valid 0). All registered outputs read 0 while rst is low and until the first post-release edge loads data.
- Bubble = valid 0, ra1/ra2/wa/res/tnew 0.
- Per-edge priority: freeze > flush[i] > stall (stage 0 only) > normal advance.
- freeze=1: all stages hold, including tnew (no decrement). flush is ignored while frozen.
- Normal advance:
  - stage 0 <= {in_ra1, in_ra2, in_wa, in_res, in_tnew, in_valid}.
  - stage i (i>=1) <= stage i-1, with tnew = (tnew_{i-1}==0) ? 0 : tnew_{i-1}-1.
- stall = stall_req | ext_stall. When stall=1 and freeze=0, stage 0 loads a bubble and stages >=1 advance normally (bubble insertion). The D tuple is held upstream, not here.
- flush[i]=1 with freeze=0: stage i loads a bubble regardless of its source. Other stages are unaffected. flush[0] together with stall yields a single bubble.
- Output latency: a tuple presented at D with stall=0 appears at stage k after k+1 edges.
- stall_req (combinational):
  - For each operand j in {1,2}, hazard_j = OR over stages i of (valid_i & wa_i!=0 & wa_i==in_raj & tnew_i > in_tusej).
  - stall_req = in_valid & (hazard_1 | hazard_2).
  - Address 0 never causes a hazard.
  - Matches against the W stage are included, so tnew_W must be 0 for correct designs. A nonzero tnew at W still stalls, and this is intentional.
- Width rules: tnew saturates at 0 and never wraps. Comparisons are unsigned, TW bits.
- Reset asserted mid-stall or mid-freeze still clears everything immediately.

Decomposition:
- Shared package/header: AW, RW, TW defaults; result-type codes (RES_NONE=0, RES_ALU, RES_LOAD, RES_PC, RES_HILO); BUBBLE constant; Tnew table per result type.
- One natural sub-module, atc_stage: a single stage register with load/hold/bubble select and a saturating tnew decrement, instantiated STAGES times via generate.
- Hazard compare stays in the top.

Test Plan:
- Reset: drive rst=0 mid-stream with stages full -> all of valid_o, wa_o, tnew_o read 0 immediately (asynchronously), and stay 0 until the first edge after rst=1.
- Flow: D tuple wa=5, res=LOAD, tnew=2, no stalls -> stage0 tnew=2 after edge 1, stage1 tnew=1 after edge 2, stage2 tnew=0 after edge 3, with wa=5 throughout.
- Load-use: stage0 valid, wa=5, tnew=2; D in_ra1=5, tuse1=1 -> stall_req=1. Next edge stage0 is a bubble and stage1 has tnew=1. With tuse1=1, stall_req=0.
- Zero register: stage0 wa=0, tnew=2; D in_ra1=0, tuse1=0 -> stall_req=0.
- Freeze and flush: freeze=1 for 3 edges -> all stages and tnew unchanged. Then flush=3'b010 with freeze=0 -> stage1 becomes a bubble while stages 0 and 2 advance.
- Priority: freeze=1 with flush=3'b111 -> no change. ext_stall=1 with flush[0]=1 -> exactly one bubble in stage 0, and the downstream stages advance.

Source files
------------

// File: rtl/atc_pipe_pkg.sv
// rtl/atc_pipe_pkg.sv - shared widths, result-type codes and Tnew table for atc_pipe
package atc_pipe_pkg;

  localparam int AW_DEF     = 5;
  localparam int RW_DEF     = 3;
  localparam int TW_DEF     = 2;
  localparam int STAGES_DEF = 3;

  typedef enum logic [RW_DEF-1:0] {
    RES_NONE = 3'd0,
    RES_ALU  = 3'd1,
    RES_LOAD = 3'd2,
    RES_PC   = 3'd3,
    RES_HILO = 3'd4
  } res_e;

  typedef struct packed {
    logic [AW_DEF-1:0] ra1;
    logic [AW_DEF-1:0] ra2;
    logic [AW_DEF-1:0] wa;
    logic [RW_DEF-1:0] res;
    logic [TW_DEF-1:0] tnew;
    logic              valid;
  } tuple_t;

  localparam tuple_t BUBBLE = '0;

  // Cycles from the E stage until the result can be forwarded.
  function automatic logic [TW_DEF-1:0] tnew_of(input res_e r);
    case (r)
      RES_ALU:  return 2'd1;
      RES_LOAD: return 2'd2;
      RES_HILO: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/atc_pipe_if.sv
// rtl/atc_pipe_if.sv - D-stage tuple, control and per-stage tracking bus for atc_pipe
interface atc_pipe_if #(
  parameter int AW     = atc_pipe_pkg::AW_DEF,
  parameter int RW     = atc_pipe_pkg::RW_DEF,
  parameter int TW     = atc_pipe_pkg::TW_DEF,
  parameter int STAGES = atc_pipe_pkg::STAGES_DEF
) ();
  logic                 in_valid;
  logic [AW-1:0]        in_ra1;
  logic [AW-1:0]        in_ra2;
  logic [AW-1:0]        in_wa;
  logic [RW-1:0]        in_res;
  logic [TW-1:0]        in_tnew;
  logic [TW-1:0]        in_tuse1;
  logic [TW-1:0]        in_tuse2;
  logic                 ext_stall;
  logic                 freeze;
  logic [STAGES-1:0]    flush;
  logic                 stall_req;
  logic [STAGES*AW-1:0] ra1_o;
  logic [STAGES*AW-1:0] ra2_o;
  logic [STAGES*AW-1:0] wa_o;
  logic [STAGES*RW-1:0] res_o;
  logic [STAGES*TW-1:0] tnew_o;
  logic [STAGES-1:0]    valid_o;

  modport master (
    output in_valid, in_ra1, in_ra2, in_wa, in_res, in_tnew, in_tuse1, in_tuse2,
    output ext_stall, freeze, flush,
    input  stall_req, ra1_o, ra2_o, wa_o, res_o, tnew_o, valid_o
  );

  modport slave (
    input  in_valid, in_ra1, in_ra2, in_wa, in_res, in_tnew, in_tuse1, in_tuse2,
    input  ext_stall, freeze, flush,
    output stall_req, ra1_o, ra2_o, wa_o, res_o, tnew_o, valid_o
  );
endinterface

// File: rtl/atc_pipe_stage.sv
// rtl/atc_pipe_stage.sv - one tracked stage: load/hold/bubble with saturating Tnew countdown
module atc_stage
  import atc_pipe_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_hold,
  input  logic          i_bubble,
  input  logic          i_dec,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  input  logic [AW-1:0] i_wa,
  input  logic [RW-1:0] i_res,
  input  logic [TW-1:0] i_tnew,
  input  logic          i_valid,
  output logic [AW-1:0] o_ra1,
  output logic [AW-1:0] o_ra2,
  output logic [AW-1:0] o_wa,
  output logic [RW-1:0] o_res,
  output logic [TW-1:0] o_tnew,
  output logic          o_valid
);
  logic [AW-1:0] r_ra1, r_ra2, r_wa;
  logic [RW-1:0] r_res;
  logic [TW-1:0] r_tnew;
  logic          r_valid;
  logic [TW-1:0] w_tnew_nxt;

  // Tnew counts down once per advance and sticks at zero.
  assign w_tnew_nxt = (i_dec && (i_tnew != '0)) ? i_tnew - TW'(1) : i_tnew;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ra1   <= '0;
      r_ra2   <= '0;
      r_wa    <= '0;
      r_res   <= '0;
      r_tnew  <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      if (i_bubble) begin
        r_ra1   <= '0;
        r_ra2   <= '0;
        r_wa    <= '0;
        r_res   <= '0;
        r_tnew  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_ra1   <= i_ra1;
        r_ra2   <= i_ra2;
        r_wa    <= i_wa;
        r_res   <= i_res;
        r_tnew  <= w_tnew_nxt;
        r_valid <= i_valid;
      end
    end
  end

  assign o_ra1   = r_ra1;
  assign o_ra2   = r_ra2;
  assign o_wa    = r_wa;
  assign o_res   = r_res;
  assign o_tnew  = r_tnew;
  assign o_valid = r_valid;
endmodule

// File: rtl/atc_pipe.sv
// rtl/atc_pipe.sv - STAGES-deep hazard-tracking pipeline with combinational stall request
module atc_pipe
  import atc_pipe_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int RW     = RW_DEF,
  parameter int TW     = TW_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  atc_pipe_if.slave  bus
);
  logic [AW-1:0] w_ra1  [STAGES];
  logic [AW-1:0] w_ra2  [STAGES];
  logic [AW-1:0] w_wa   [STAGES];
  logic [RW-1:0] w_res  [STAGES];
  logic [TW-1:0] w_tnew [STAGES];
  logic          w_valid[STAGES];
  logic          w_stall;
  logic          w_haz1;
  logic          w_haz2;

  assign w_stall = bus.stall_req | bus.ext_stall;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      // A stall only turns the entering tuple into a bubble; D holds it upstream.
      atc_stage #(.AW(AW), .RW(RW), .TW(TW)) u_stage (
        .clk(clk), .rst(rst),
        .i_hold(bus.freeze), .i_bubble(bus.flush[0] | w_stall), .i_dec(1'b0),
        .i_ra1(bus.in_ra1), .i_ra2(bus.in_ra2), .i_wa(bus.in_wa),
        .i_res(bus.in_res), .i_tnew(bus.in_tnew), .i_valid(bus.in_valid),
        .o_ra1(w_ra1[g]), .o_ra2(w_ra2[g]), .o_wa(w_wa[g]),
        .o_res(w_res[g]), .o_tnew(w_tnew[g]), .o_valid(w_valid[g])
      );
    end else begin : g_rest
      atc_stage #(.AW(AW), .RW(RW), .TW(TW)) u_stage (
        .clk(clk), .rst(rst),
        .i_hold(bus.freeze), .i_bubble(bus.flush[g]), .i_dec(1'b1),
        .i_ra1(w_ra1[g-1]), .i_ra2(w_ra2[g-1]), .i_wa(w_wa[g-1]),
        .i_res(w_res[g-1]), .i_tnew(w_tnew[g-1]), .i_valid(w_valid[g-1]),
        .o_ra1(w_ra1[g]), .o_ra2(w_ra2[g]), .o_wa(w_wa[g]),
        .o_res(w_res[g]), .o_tnew(w_tnew[g]), .o_valid(w_valid[g])
      );
    end
    assign bus.ra1_o[g*AW +: AW]  = w_ra1[g];
    assign bus.ra2_o[g*AW +: AW]  = w_ra2[g];
    assign bus.wa_o[g*AW +: AW]   = w_wa[g];
    assign bus.res_o[g*RW +: RW]  = w_res[g];
    assign bus.tnew_o[g*TW +: TW] = w_tnew[g];
    assign bus.valid_o[g]         = w_valid[g];
  end

  // W is included on purpose: a nonzero Tnew surviving to W still stalls.
  always_comb begin
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (w_valid[i] && (w_wa[i] != '0) && (w_wa[i] == bus.in_ra1) && (w_tnew[i] > bus.in_tuse1))
        w_haz1 = 1'b1;
      if (w_valid[i] && (w_wa[i] != '0) && (w_wa[i] == bus.in_ra2) && (w_tnew[i] > bus.in_tuse2))
        w_haz2 = 1'b1;
    end
  end

  assign bus.stall_req = bus.in_valid & (w_haz1 | w_haz2);
endmodule

// File: tb/tb_atc_pipe.sv
// tb/tb_atc_pipe.sv - self-checking bench for atc_pipe
module tb_atc_pipe;
  import atc_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  atc_pipe_if #(.AW(5), .RW(3), .TW(2), .STAGES(3)) bus ();
  atc_pipe #(.AW(5), .RW(3), .TW(2), .STAGES(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0] wa;
    logic [1:0] tnew;
    int         edges;
    logic       dv;
    logic [4:0] ra1;
    logic [1:0] tu1;
    logic [4:0] ra2;
    logic [1:0] tu2;
    logic       exp_stall;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [4:0] wa;
    logic [2:0] res;
    logic [1:0] tnew;
  } wexp_t;

  vec_t  vecs[9];
  wexp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic [4:0] wa, input logic [2:0] res, input logic [1:0] tnew,
                       input logic [1:0] tu1, input logic [1:0] tu2);
    bus.in_valid = v;   bus.in_ra1 = ra1;   bus.in_ra2 = ra2; bus.in_wa = wa;
    bus.in_res   = res; bus.in_tnew = tnew; bus.in_tuse1 = tu1; bus.in_tuse2 = tu2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 2'd0, 2'd0, 2'd0);
    bus.ext_stall = 1'b0; bus.freeze = 1'b0; bus.flush = 3'b000;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0; tick(); rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] t;
    logic       es;
    logic [4:0] wa;
    res_e       rs;
    wexp_t      e, got;

    vecs[0] = '{5'd5, 2'd2, 1, 1'b1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1};
    vecs[1] = '{5'd5, 2'd2, 1, 1'b1, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0};
    vecs[2] = '{5'd0, 2'd2, 1, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0};
    vecs[3] = '{5'd5, 2'd1, 1, 1'b1, 5'd0, 2'd0, 5'd5, 2'd0, 1'b1};
    vecs[4] = '{5'd5, 2'd3, 1, 1'b1, 5'd6, 2'd0, 5'd0, 2'd0, 1'b0};
    vecs[5] = '{5'd7, 2'd3, 2, 1'b1, 5'd0, 2'd0, 5'd7, 2'd1, 1'b1};
    vecs[6] = '{5'd5, 2'd2, 1, 1'b0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0};
    vecs[7] = '{5'd5, 2'd3, 3, 1'b1, 5'd5, 2'd0, 5'd0, 2'd0, 1'b1};
    vecs[8] = '{5'd5, 2'd2, 3, 1'b1, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0};

    idle();
    #1;
    chk("reset_valid", 64'(bus.valid_o), 64'd0);
    chk("reset_wa", 64'(bus.wa_o), 64'd0);
    chk("reset_tnew", 64'(bus.tnew_o), 64'd0);
    tick(); rst = 1'b1;

    // Flow: a LOAD tuple walks E->M->W with Tnew counting down.
    drive(1'b1, 5'd0, 5'd0, 5'd5, RES_LOAD, tnew_of(RES_LOAD), 2'd0, 2'd0);
    tick();
    chk("flow_s0", {59'd0, bus.wa_o[4:0]}, 64'd5);
    chk("flow_s0_tnew", 64'(bus.tnew_o[1:0]), 64'd2);
    idle(); tick();
    chk("flow_s1", {56'd0, bus.wa_o[9:5], bus.tnew_o[3:2], bus.res_o[5:3]}, {56'd0, 5'd5, 2'd1, 3'(RES_LOAD)});
    tick();
    chk("flow_s2", {56'd0, bus.wa_o[14:10], bus.tnew_o[5:4], bus.valid_o[2], 2'd0}, {56'd0, 5'd5, 2'd0, 1'b1, 2'd0});

    // Table of single-stage hazard setups.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      drive(1'b1, 5'd0, 5'd0, vecs[v].wa, RES_ALU, vecs[v].tnew, 2'd0, 2'd0);
      tick();
      for (int k = 1; k < vecs[v].edges; k++) begin idle(); tick(); end
      drive(vecs[v].dv, vecs[v].ra1, vecs[v].ra2, 5'd0, RES_NONE, 2'd0, vecs[v].tu1, vecs[v].tu2);
      #1;
      t = (vecs[v].tnew > 2'(vecs[v].edges - 1)) ? vecs[v].tnew - 2'(vecs[v].edges - 1) : 2'd0;
      chk($sformatf("vec%0d_stall", v), 64'(bus.stall_req), 64'(vecs[v].exp_stall));
      chk($sformatf("vec%0d_tnew", v), 64'(bus.tnew_o[(vecs[v].edges-1)*2 +: 2]), 64'(t));
      idle();
    end

    // Load-use: stall inserts a bubble, and the hazard clears one edge later.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd5, RES_LOAD, 2'd2, 2'd0, 2'd0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd9, RES_ALU, 2'd1, 2'd1, 2'd0);
    #1;
    chk("lu_stall", 64'(bus.stall_req), 64'd1);
    tick();
    chk("lu_bubble", {57'd0, bus.valid_o, bus.wa_o[4:0], bus.tnew_o[3:2], bus.wa_o[9:5]},
        {57'd0, 3'b010, 5'd0, 2'd1, 5'd5});
    chk("lu_clear", 64'(bus.stall_req), 64'd0);

    // Freeze (with flush ignored), then a mid-stage flush, then stall+flush[0].
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd1, RES_ALU, 2'd3, 2'd0, 2'd0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd2, RES_ALU, 2'd3, 2'd0, 2'd0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd3, RES_ALU, 2'd3, 2'd0, 2'd0); tick();
    chk("fill", {49'd0, bus.valid_o, bus.wa_o, bus.tnew_o[5:0], 1'b0},
        {49'd0, 3'b111, 5'd1, 5'd2, 5'd3, 2'd1, 2'd2, 2'd3, 1'b0});
    drive(1'b1, 5'd0, 5'd0, 5'd4, RES_ALU, 2'd3, 2'd0, 2'd0);
    bus.freeze = 1'b1; bus.flush = 3'b111;
    tick(); bus.flush = 3'b000; tick(); tick();
    chk("freeze_hold", {49'd0, bus.valid_o, bus.wa_o, bus.tnew_o[5:0], 1'b0},
        {49'd0, 3'b111, 5'd1, 5'd2, 5'd3, 2'd1, 2'd2, 2'd3, 1'b0});
    bus.freeze = 1'b0; bus.flush = 3'b010;
    tick();
    chk("flush_mid", {49'd0, bus.valid_o, bus.wa_o, bus.tnew_o[5:0], 1'b0},
        {49'd0, 3'b101, 5'd2, 5'd0, 5'd4, 2'd1, 2'd0, 2'd3, 1'b0});
    drive(1'b1, 5'd0, 5'd0, 5'd6, RES_ALU, 2'd2, 2'd0, 2'd0);
    bus.flush = 3'b001; bus.ext_stall = 1'b1;
    tick();
    chk("stall_flush0", {49'd0, bus.valid_o, bus.wa_o, bus.tnew_o[5:0], 1'b0},
        {49'd0, 3'b010, 5'd0, 5'd4, 5'd0, 2'd0, 2'd2, 2'd0, 1'b0});

    // Asynchronous reset with the pipe full.
    idle();
    drive(1'b1, 5'd0, 5'd0, 5'd7, RES_ALU, 2'd3, 2'd0, 2'd0); tick(); tick(); tick();
    #3; rst = 1'b0; #1;
    chk("async_rst", {48'd0, bus.valid_o, bus.wa_o, bus.tnew_o[5:0], 2'd0}, 64'd0);
    tick();
    chk("rst_held", {48'd0, bus.valid_o, bus.wa_o, bus.tnew_o[5:0], 2'd0}, 64'd0);
    rst = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd9, RES_ALU, 2'd1, 2'd0, 2'd0);
    #2;
    chk("rst_release", 64'(bus.valid_o), 64'd0);
    tick();
    chk("rst_first_load", {58'd0, bus.valid_o[0], bus.wa_o[4:0]}, {58'd0, 1'b1, 5'd9});

    // Scoreboard stream: expected W-stage contents queued as each D tuple is driven.
    do_reset();
    sb.delete();
    e = '{1'b0, 5'd0, 3'd0, 2'd0};
    sb.push_back(e); sb.push_back(e);
    for (int c = 0; c < 40; c++) begin
      wa = 5'($urandom_range(1, 31));
      rs = res_e'(3'($urandom_range(0, 4)));
      es = ($urandom_range(0, 3) == 0);
      drive(1'b1, 5'd0, 5'd0, wa, rs, tnew_of(rs), 2'd0, 2'd0);
      bus.ext_stall = es;
      if (es) e = '{1'b0, 5'd0, 3'd0, 2'd0};
      else    e = '{1'b1, wa, 3'(rs), (tnew_of(rs) >= 2'd2) ? tnew_of(rs) - 2'd2 : 2'd0};
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      got = '{bus.valid_o[2], bus.wa_o[14:10], bus.res_o[8:6], bus.tnew_o[5:4]};
      chk($sformatf("sb_w%0d", c), {53'd0, got.valid, got.wa, got.res, got.tnew},
          {53'd0, e.valid, e.wa, e.res, e.tnew});
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
